// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: shadow-entry layout,
// controller states and the register that JAL writes its link into.
package pipe_pkg;

  localparam int REG_W   = 4;
  localparam int NUM_ENT = 3;
  localparam int ENT_EX  = 0;
  localparam int ENT_DM  = 1;
  localparam int ENT_WB  = 2;

  localparam logic [REG_W-1:0] JAL_LINK_REG = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Field order from MSB: v, we, dst[3:0], halt.
  typedef struct packed {
    logic             v;
    logic             we;
    logic [REG_W-1:0] dst;
    logic             halt;
  } shadow_t;

  localparam int ENT_W = $bits(shadow_t);

  // An entry can hazard only if it will really write a register.
  function automatic logic is_live(shadow_t e, bit r0_zero);
    return e.v && e.we && (!r0_zero || (e.dst != '0));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_cmp.sv
// Compares one ID source register against the live shadow entries; the WB
// entry is only in scope when the register file cannot bypass its own write.
module hz_cmp
  import pipe_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic                          src_used_i,
  input  logic [REG_W-1:0]              src_i,
  input  logic [NUM_ENT-1:0]            live_i,
  input  logic [NUM_ENT-1:0][REG_W-1:0] dst_i,
  output logic                          match_o
);

  localparam logic [NUM_ENT-1:0] SCOPE = RF_BYPASS ? 3'b011 : 3'b111;

  logic [NUM_ENT-1:0] hit;

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      hit[i] = live_i[i] && (dst_i[i] == src_i);
    end
  end

  assign match_o = src_used_i && |(hit & SCOPE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/ID/EX/DM/WB pipe: RAW-hazard stalls from a
// shadow scoreboard, redirect flushes, and halt draining.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1,
  parameter bit R0_ZERO   = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_used,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_used,
  input  logic             id_we,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_halt,
  input  logic             dm_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_dm_flush,
  output logic             hlt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e                        state_q, state_d;
  shadow_t                       ex_q, dm_q, wb_q, ex_d, dm_d, wb_d;
  logic                          hlt_q, hlt_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_ENT-1:0]            live;
  logic [NUM_ENT-1:0][REG_W-1:0] dsts;
  logic                          rs1_hit, rs2_hit, hz;
  logic                          in_run, accept, stall_cyc;

  always_comb begin
    live[ENT_EX] = is_live(ex_q, R0_ZERO);
    live[ENT_DM] = is_live(dm_q, R0_ZERO);
    live[ENT_WB] = is_live(wb_q, R0_ZERO);
    dsts[ENT_EX] = ex_q.dst;
    dsts[ENT_DM] = dm_q.dst;
    dsts[ENT_WB] = wb_q.dst;
  end

  hz_cmp #(.RF_BYPASS(RF_BYPASS)) u_rs1_cmp (
    .src_used_i(id_rs1_used), .src_i(id_rs1), .live_i(live), .dst_i(dsts), .match_o(rs1_hit)
  );

  hz_cmp #(.RF_BYPASS(RF_BYPASS)) u_rs2_cmp (
    .src_used_i(id_rs2_used), .src_i(id_rs2), .live_i(live), .dst_i(dsts), .match_o(rs2_hit)
  );

  assign hz        = id_valid && (rs1_hit || rs2_hit);
  assign in_run    = (state_q == ST_RUN);
  assign stall_cyc = in_run && hz && !dm_redirect;
  assign accept    = in_run && id_valid && !hz && !dm_redirect;

  // Redirect squashes the two younger entries; the redirecting one retires.
  always_comb begin
    ex_d = '0;
    dm_d = dm_redirect ? '0 : ex_q;
    wb_d = dm_q;
    if (accept) ex_d = '{v: 1'b1, we: id_we, dst: id_dst, halt: id_halt};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && id_halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (dm_redirect)                state_d = ST_RUN;
        else if (wb_q.v && wb_q.halt)   state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  assign hlt_d = (state_d == ST_HALTED);
  assign cnt_d = (stall_cyc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking here would let the EX->DM->WB shift collapse in one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      dm_q  <= '0;
      wb_q  <= '0;
      hlt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      dm_q  <= dm_d;
      wb_q  <= wb_d;
      hlt_q <= hlt_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: every output gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_dm_flush  = 1'b0;
    if (rst_n) begin
      if (state_q == ST_HALTED) begin
        {pc_stall, if_id_stall, id_ex_bubble} = 3'b111;
      end else if (dm_redirect) begin
        {if_id_flush, id_ex_flush, ex_dm_flush} = 3'b111;
      end else if (state_q == ST_DRAIN) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end else if (hz) begin
        {pc_stall, if_id_stall, id_ex_bubble} = 3'b111;
      end
    end
  end

  assign hlt       = hlt_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario and randomized bench for pipe_hazard_ctrl against an in-flight
// instruction list model; a 2-bit-counter twin exercises saturation.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int   CNT_W   = 16;
  localparam int   SAT_W   = 2;
  localparam int   SCOPE   = 2;     // write-first RF: producers visible in EX and DM only
  localparam logic R0_ZERO = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used, id_we, id_halt, dm_redirect;
  logic [3:0] id_rs1, id_rs2, id_dst;
  logic pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, ex_dm_flush, hlt;
  logic [CNT_W-1:0] stall_cnt;
  logic s_pc_stall, s_if_id_stall, s_id_ex_bubble, s_if_id_flush, s_id_ex_flush, s_ex_dm_flush, s_hlt;
  logic [SAT_W-1:0] s_stall_cnt;

  pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .R0_ZERO(1'b1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_dst(id_dst), .id_halt(id_halt),
    .dm_redirect(dm_redirect), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_dm_flush(ex_dm_flush), .hlt(hlt), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .R0_ZERO(1'b1), .CNT_W(SAT_W)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_dst(id_dst), .id_halt(id_halt),
    .dm_redirect(dm_redirect), .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
    .id_ex_bubble(s_id_ex_bubble), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_dm_flush(s_ex_dm_flush), .hlt(s_hlt), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: accepted instructions with their position past ID (0=EX,1=DM,2=WB).
  typedef struct {
    logic       we;
    logic [3:0] dst;
    logic       halt;
    int         pos;
  } rec_t;

  rec_t inflight[$];
  bit   m_drain, m_halted, m_hlt;
  int   m_cnt;
  int   n_pass, n_total;

  logic [6:0]       obs_o, obs_s, exp_o;
  logic [CNT_W-1:0] obs_c, exp_c;
  logic [SAT_W-1:0] obs_sc, exp_sc;

  task automatic model_reset();
    inflight.delete();
    m_drain  = 0;
    m_halted = 0;
    m_hlt    = 0;
    m_cnt    = 0;
  endtask

  function automatic bit m_hz();
    if (!id_valid) return 1'b0;
    foreach (inflight[i]) begin
      if (!inflight[i].we || inflight[i].pos >= SCOPE) continue;
      if (R0_ZERO && inflight[i].dst == 4'd0) continue;
      if ((id_rs1_used && id_rs1 == inflight[i].dst) || (id_rs2_used && id_rs2 == inflight[i].dst))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Bit order: pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, ex_dm_flush, hlt.
  function automatic logic [6:0] model_outs();
    logic [6:0] e;
    e = '0;
    if (!rst_n) return e;
    if (m_halted)        e[6:4] = 3'b111;
    else if (dm_redirect) e[3:1] = 3'b111;
    else if (m_drain)    begin e[6] = 1'b1; e[3] = 1'b1; end
    else if (m_hz())     e[6:4] = 3'b111;
    e[0] = m_hlt;
    return e;
  endfunction

  task automatic model_step();
    bit   hz, run, accept, halt_wb;
    rec_t r;
    rec_t keep[$];
    if (!rst_n) begin
      model_reset();
      return;
    end
    hz      = m_hz();
    run     = !m_drain && !m_halted;
    accept  = run && id_valid && !hz && !dm_redirect;
    halt_wb = 0;
    foreach (inflight[i]) if (inflight[i].pos == 2 && inflight[i].halt) halt_wb = 1;
    if (run && hz && !dm_redirect && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    foreach (inflight[i]) begin
      if (dm_redirect && inflight[i].pos == 0) continue;   // younger than the redirect
      if (inflight[i].pos == 2) continue;                  // retires
      r = inflight[i];
      r.pos++;
      keep.push_back(r);
    end
    inflight = keep;
    if (accept) begin
      r.we = id_we; r.dst = id_dst; r.halt = id_halt; r.pos = 0;
      inflight.push_back(r);
    end
    if (m_drain) begin
      if (dm_redirect) m_drain = 0;
      else if (halt_wb) begin m_drain = 0; m_halted = 1; m_hlt = 1; end
    end else if (accept && id_halt) begin
      m_drain = 1;
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] rs1, input bit u1, input logic [3:0] rs2,
                       input bit u2, input bit we, input logic [3:0] dst, input bit halt, input bit redir);
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_we = we;    id_dst = dst; id_halt = halt;   dm_redirect = redir;
  endtask

  task automatic idle();
    drive(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0);
  endtask

  task automatic observe();
    obs_o  = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, ex_dm_flush, hlt};
    obs_s  = {s_pc_stall, s_if_id_stall, s_id_ex_bubble, s_if_id_flush, s_id_ex_flush, s_ex_dm_flush, s_hlt};
    obs_c  = stall_cnt;
    obs_sc = s_stall_cnt;
    exp_o  = model_outs();
    exp_c  = CNT_W'(m_cnt);
    exp_sc = (m_cnt > 3) ? 2'd3 : SAT_W'(m_cnt);
  endtask

  task automatic sample();
    @(negedge clk);
    observe();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asserts rst_n between edges with busy inputs, then releases on a falling edge.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    drive(1, 4'd3, 1, 4'd3, 1, 1, 4'd3, 1, 1);
    #1;
    observe();
    n_total++;
    if ({obs_o, obs_c, obs_s, obs_sc} !== '0)
      $display("FAIL %s_async outs=%b cnt=%0d sat=%b/%0d expected all zero", tag, obs_o, obs_c, obs_s, obs_sc);
    else n_pass++;
    model_reset();
    repeat (2) advance();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    advance();
  endtask

  task automatic test_reset();
    apply_reset("reset");
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c})
      $display("FAIL reset_idle outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
  endtask

  task automatic test_raw_stall();
    int stalls = 0;
    bit done = 0;
    drive(1, 4'd1, 1, 4'd2, 1, 1, 4'd3, 0, 0);   // ADD R3
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c})
      $display("FAIL raw_writer outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
    drive(1, 4'd3, 1, 4'd0, 0, 1, 4'd4, 0, 0);   // reads R3
    for (int k = 0; k < 6 && !done; k++) begin
      sample();
      n_total++;
      if ({obs_o, obs_c} !== {exp_o, exp_c})
        $display("FAIL raw_reader outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
      else n_pass++;
      if (!obs_o[6]) done = 1;
      else if (obs_o[4]) stalls++;
      advance();
    end
    n_total++;
    if (!done || stalls != 2 || obs_c !== 16'd2)
      $display("FAIL raw_count stall_cycles=%0d cnt=%0d done=%0d expected 2/2/1", stalls, obs_c, done);
    else n_pass++;
  endtask

  task automatic test_r0_writer();
    int cnt_before = m_cnt;
    drive(1, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0);   // writes R0
    advance();
    drive(1, 4'd0, 1, 4'd0, 1, 0, 4'd0, 0, 0);   // reads R0
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c} || obs_o[6] !== 1'b0 || obs_c !== CNT_W'(cnt_before))
      $display("FAIL r0_reader outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, CNT_W'(cnt_before));
    else n_pass++;
    advance();
    idle();
    advance();
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq_dst [4] = '{4'd7, 4'd8, JAL_LINK_REG, 4'd0};
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd0, 0, 4'd0, 0, 1, seq_dst[i], 0, 0);
      advance();
    end
    drive(1, 4'd7, 1, JAL_LINK_REG, 1, 0, 4'd0, 0, 0);   // JR R15 style reader
    for (int k = 0; k < 5; k++) begin
      sample();
      n_total++;
      if ({obs_o, obs_c} !== {exp_o, exp_c})
        $display("FAIL b2b_reader k=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", k, obs_o, obs_c, exp_o, exp_c);
      else n_pass++;
      advance();
      if (!obs_o[6]) idle();
    end
  endtask

  task automatic test_redirect();
    drive(1, 4'd0, 0, 4'd0, 0, 1, 4'd5, 0, 0);   // writes R5
    advance();
    drive(1, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0, 1);   // R5 reader while DM redirects
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c} || obs_o[6:1] !== 6'b000111)
      $display("FAIL redirect_flush outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
    drive(1, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0, 0);
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c} || obs_o[6] !== 1'b0)
      $display("FAIL redirect_after outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
    idle();
  endtask

  task automatic test_halt();
    int drain = 0, held = 0;
    drive(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0);
    advance();
    idle();
    for (int k = 0; k < 13; k++) begin
      sample();
      n_total++;
      if ({obs_o, obs_c} !== {exp_o, exp_c})
        $display("FAIL halt_seq k=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", k, obs_o, obs_c, exp_o, exp_c);
      else n_pass++;
      if (k < 3 && obs_o[6] && obs_o[3] && !obs_o[0]) drain++;
      if (k >= 3 && obs_o[0] && obs_o[6:4] == 3'b111) held++;
      advance();
    end
    n_total++;
    if (drain != 3 || held != 10)
      $display("FAIL halt_timing drain_cycles=%0d hlt_cycles=%0d expected 3/10", drain, held);
    else n_pass++;
    apply_reset("halt_exit");
  endtask

  task automatic test_halt_squash();
    int bad = 0;
    drive(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0);
    advance();
    drive(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1);
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c} || obs_o[6:1] !== 6'b000111)
      $display("FAIL squash_redirect outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
    idle();
    for (int k = 0; k < 6; k++) begin
      sample();
      if (obs_o[0] || obs_o[6]) bad++;
      advance();
    end
    n_total++;
    if (bad != 0) $display("FAIL squash_run hlt_or_stall_cycles=%0d expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] wr [3] = '{4'd1, 4'd2, 4'd6};
    int gap [3] = '{0, 0, 1};
    apply_reset("pre_drain");
    for (int p = 0; p < 3; p++) begin
      drive(1, 4'd0, 0, 4'd0, 0, 1, wr[p], 0, 0);
      advance();
      idle();
      repeat (gap[p]) advance();
      drive(1, wr[p], 1, 4'd0, 0, 0, 4'd0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        sample();
        advance();
        if (!obs_o[6]) break;
      end
    end
    idle();
    sample();
    n_total++;
    if (obs_c !== 16'd5 || exp_c !== 16'd5)
      $display("FAIL mid_drain_setup cnt=%0d model=%0d expected 5", obs_c, exp_c);
    else n_pass++;
    advance();
    drive(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0);
    advance();
    idle();
    sample();
    n_total++;
    if ({obs_o, obs_c} !== {exp_o, exp_c} || obs_o !== 7'b1001000)
      $display("FAIL mid_drain_state outs=%b cnt=%0d expected outs=%b cnt=%0d", obs_o, obs_c, exp_o, exp_c);
    else n_pass++;
    advance();
    apply_reset("mid_drain");
    drive(1, 4'd0, 0, 4'd0, 0, 1, 4'd9, 0, 0);
    advance();
    drive(1, 4'd9, 1, 4'd0, 0, 0, 4'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      sample();
      n_total++;
      if ({obs_o, obs_c} !== {exp_o, exp_c})
        $display("FAIL post_reset k=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", k, obs_o, obs_c, exp_o, exp_c);
      else n_pass++;
      advance();
    end
    idle();
    n_total++;
    if (stall_cnt !== 16'd2) $display("FAIL post_reset_cnt cnt=%0d expected 2", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int halted_for = 0;
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 9) < 8), 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 11) == 0));
      sample();
      n_total++;
      if ({obs_o, obs_c, obs_s, obs_sc} !== {exp_o, exp_c, exp_o, exp_sc})
        $display("FAIL random k=%0d outs=%b cnt=%0d sat=%b/%0d expected outs=%b cnt=%0d sat_cnt=%0d",
                 k, obs_o, obs_c, obs_s, obs_sc, exp_o, exp_c, exp_sc);
      else n_pass++;
      advance();
      if (m_halted) halted_for++;
      if (halted_for > 4 || $urandom_range(0, 299) == 0) begin
        apply_reset("random");
        halted_for = 0;
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    idle();
    test_reset();
    test_raw_stall();
    test_r0_writer();
    test_back_to_back();
    test_redirect();
    test_halt();
    test_halt_squash();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage IF/ID/EX/DM/WB pipeline. The pipeline has no forwarding, so this block keeps a shadow scoreboard of in-flight register writes and raises stalls on read-after-write hazards. It flushes younger stages when a branch or jump redirects in DM, and drains the pipe on a halt before asserting hlt. Its outputs drive the enable and clear pins of the PC register and the IF/ID, ID/EX and EX/DM pipeline flops.

Parameters:
RF_BYPASS, 1, 1 = register file is write-first, so a producer in WB does not cause a hazard; 0 = WB producer also stalls.
R0_ZERO, 1, 1 = destination register 0 never creates a hazard.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  4  first source register in ID
id_rs1_used  in  1  rs1 is actually read
id_rs2  in  4  second source register in ID
id_rs2_used  in  1  rs2 is actually read
id_we  in  1  ID instruction writes the register file
id_dst  in  4  ID destination register (JAL already mapped to R15)
id_halt  in  1  ID instruction is HLT
dm_redirect  in  1  instruction in DM takes a branch, JAL or JR
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_bubble  out  1  load a NOP into ID/EX
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX
ex_dm_flush  out  1  clear EX/DM
hlt  out  1  processor halted (sticky)
stall_cnt  out  CNT_W  number of hazard-stall cycles, saturating

Behaviour:
- Shadow pipe: entries EX, DM and WB, each holding {v, we, dst[3:0], halt}. Every clock the entries shift EX->DM->WB.
- The EX entry loads the ID fields when ID is accepted. It loads all zeros on a stall, a flush, or when id_valid=0.
- Hazard, combinational:
  - A live entry is one with v & we, and dst != 0 when R0_ZERO=1.
  - hz = id_valid & ((id_rs1_used & id_rs1 matches a live EX/DM entry) | (id_rs2_used & id_rs2 matches a live EX/DM entry)).
  - When RF_BYPASS=0, the WB entry is also included in the match.
- Stall cycle (hz & !dm_redirect & state==RUN): pc_stall = if_id_stall = id_ex_bubble = 1.
- Redirect cycle (dm_redirect=1):
  - if_id_flush = id_ex_flush = ex_dm_flush = 1; stalls are 0.
  - Next EX entry and next DM entry are cleared; the WB entry receives the redirecting DM entry.
  - Redirect takes priority over hazard and over DRAIN.
- FSM states: RUN, DRAIN, HALTED.
  - RUN->DRAIN: id_halt & id_valid & !hz & !dm_redirect. The halt bit enters the EX entry.
  - DRAIN outputs: pc_stall=1 and if_id_flush=1 every cycle; younger fetches are discarded.
  - DRAIN->RUN: dm_redirect=1. The halt was on a wrong path and has been squashed.
  - DRAIN->HALTED: the WB entry has v & halt.
  - HALTED outputs: hlt=1, pc_stall=1, if_id_stall=1, id_ex_bubble=1, flushes 0. HALTED is exited only by reset.
- hlt is registered and asserts the cycle after the halt entry reaches WB.
- stall_cnt increments on each stall cycle and saturates at all-ones. DRAIN and HALTED cycles are not counted.
- Reset (asynchronous, any time, including mid-DRAIN):
  - Shadow entries cleared, state=RUN, hlt=0, stall_cnt=0.
  - All combinational outputs are 0 while rst_n=0.
- Latency: stall and flush outputs are combinational within the same cycle as their cause. Hazard stalls last at most 2 cycles (3 when RF_BYPASS=0).
- Simultaneous hz and id_halt: the halt is not accepted until hz clears.

Decomposition:
- Shared package pipe_pkg:
  - localparams for shadow entry field widths and offsets.
  - FSM state encodings: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - R15 as JAL_LINK_REG.
- One natural sub-module: hz_cmp, which compares one source register against the shadow entries and returns a match. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
1. ADD R3 then, back-to-back, an instruction with rs1=R3 (RF_BYPASS=1) -> exactly 2 stall cycles, id_ex_bubble=1 in both, stall_cnt=2.
2. Writer with dst=R0, then a reader of R0 -> no stall, stall_cnt stays 0.
3. Branch reaches DM with dm_redirect=1 while ID holds a hazarding reader -> all three flushes=1, pc_stall=0; next cycle the shadow EX/DM entries are invalid and no stall occurs.
4. HLT accepted in ID -> DRAIN for 3 cycles with pc_stall=1 and if_id_flush=1; hlt=1 on the 4th edge and held for 10 further cycles.
5. HLT accepted, then dm_redirect=1 on the next cycle -> state returns to RUN and hlt never asserts.
6. rst_n pulsed low mid-DRAIN with stall_cnt=5 -> hlt=0, stall_cnt=0, all outputs 0 asynchronously; normal fetch resumes after rst_n rises.
